// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit for the EX stage.
// Stalls the pipeline while iterating and returns one result with a valid pulse.
module ex_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    input  logic [XLEN-1:0] inReg1,
    input  logic [XLEN-1:0] inReg2,
    input  logic [2:0]      inFun3,
    input  logic [4:0]      inWrReg,
    input  logic            flush,
    output logic            outStall,
    output logic            outValid,
    output logic [XLEN-1:0] outResult,
    output logic [4:0]      outWrReg,
    output logic            busy
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          fun3_q;
    logic [4:0]          wr_q;
    logic                sign_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]     mplier_q;
    logic [XLEN:0]       rem_q;
    logic [XLEN-1:0]     quo_q;
    logic [XLEN-1:0]     div_q;
    logic                out_valid_q;
    logic [XLEN-1:0]     out_res_q;
    logic [4:0]          out_wr_q;

    logic                sgn_a;
    logic                sgn_b;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic                is_div;
    logic                is_rem;
    logic                div0;
    logic                ovf;
    logic                sign_st;
    logic [XLEN-1:0]     sp_res;

    logic [2*XLEN-1:0]   acc_d;
    logic [XLEN+1:0]     sh_d;
    logic [XLEN+1:0]     diff_d;
    logic [XLEN:0]       rem_d;
    logic [XLEN-1:0]     quo_d;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     res_d;

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        unique case (inFun3)
            3'b001, 3'b100, 3'b110: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            3'b010:  sgn_a = 1'b1;
            default: ;
        endcase
    end

    assign a_neg   = sgn_a & inReg1[XLEN-1];
    assign b_neg   = sgn_b & inReg2[XLEN-1];
    assign a_mag   = a_neg ? -inReg1 : inReg1;
    assign b_mag   = b_neg ? -inReg2 : inReg2;
    assign is_div  = inFun3[2];
    assign is_rem  = inFun3[2] & inFun3[1];
    assign div0    = is_div && (inReg2 == '0);
    assign ovf     = is_div && !inFun3[0]
                   && (inReg1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (inReg2 == '1);
    // Remainder sign follows the dividend; everything else is the xor.
    assign sign_st = is_rem ? a_neg : (a_neg ^ b_neg);
    assign sp_res  = div0 ? (is_rem ? inReg1 : '1)
                          : (is_rem ? '0 : inReg1);

    always_comb begin
        acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
        sh_d   = {rem_q, quo_q[XLEN-1]};
        diff_d = sh_d - {2'b00, div_q};
        quo_d  = {quo_q[XLEN-2:0], ~diff_d[XLEN+1]};
        rem_d  = diff_d[XLEN+1] ? sh_d[XLEN:0] : diff_d[XLEN:0];
    end

    // Fixup uses the final-step values so the result lands as DONE begins.
    always_comb begin
        prod_s = sign_q ? -acc_d : acc_d;
        quo_s  = sign_q ? -quo_d : quo_d;
        rem_s  = sign_q ? -rem_d[XLEN-1:0] : rem_d[XLEN-1:0];
        unique case (fun3_q)
            3'b000:                 res_d = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_d = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_d = quo_s;
            default:                res_d = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fun3_q      <= '0;
            wr_q        <= '0;
            sign_q      <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_wr_q    <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (inValid) begin
                        fun3_q <= inFun3;
                        wr_q   <= inWrReg;
                        sign_q <= sign_st;
                        if (div0 || ovf) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_res_q   <= sp_res;
                            out_wr_q    <= inWrReg;
                        end else begin
                            state_q  <= CALC;
                            cnt_q    <= CW'(XLEN);
                            acc_q    <= '0;
                            mcand_q  <= {{XLEN{1'b0}}, a_mag};
                            mplier_q <= b_mag;
                            rem_q    <= '0;
                            quo_q    <= a_mag;
                            div_q    <= b_mag;
                        end
                    end
                end
                CALC: begin
                    cnt_q    <= cnt_q - CW'(1);
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    rem_q    <= rem_d;
                    quo_q    <= quo_d;
                    if (cnt_q == CW'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_res_q   <= res_d;
                        out_wr_q    <= wr_q;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign outStall  = rst_n
                     && (((state_q == IDLE) && inValid && !flush)
                         || (state_q == CALC));
    assign outValid  = out_valid_q;
    assign outResult = out_res_q;
    assign outWrReg  = out_wr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative 64-bit RV64M multiply/divide unit in the EX stage, on the consuming side of the ID/EX pipeline register. It reads the registered operands, fun3 and destination register that ID/EX presents, and computes the result over many cycles. While computing it holds the pipeline frozen through a stall output. It then returns one result with a one-cycle valid pulse to the EX/MEM path.

## Interface
Parameters:
- XLEN, default 64: operand and result width; the iteration count equals XLEN.

Ports (name, direction, width, meaning):
- clk, input, 1: sole clock; everything samples on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- inValid, input, 1: the ID/EX entry holds an M-extension op (R-type, fun7 = 7'b0000001).
- inReg1, input, XLEN: rs1 operand from ID/EX.
- inReg2, input, XLEN: rs2 operand from ID/EX.
- inFun3, input, 3: op select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- inWrReg, input, 5: destination register address from ID/EX.
- flush, input, 1: synchronous kill of the in-flight op (branch redirect).
- outStall, output, 1: freezes the PC, IF/ID and ID/EX.
- outValid, output, 1: one-cycle pulse; outResult and outWrReg are valid.
- outResult, output, XLEN: the result.
- outWrReg, output, 5: destination register captured at start.
- busy, output, 1: high in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: when inValid=1 and flush=0, the unit latches the operands, inFun3 and inWrReg.
  - Signed ops (MULH, DIV, REM; rs1 only for MULHSU) convert operands to magnitudes.
  - The unit records the result sign, loads the iteration counter with XLEN, and moves to CALC.
- Special cases go IDLE -> DONE directly with no iteration:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow, DIV of 0x8000_0000_0000_0000 by -1: quotient = rs1, REM = 0.
- CALC multiply: radix-2 shift-add into a 2*XLEN accumulator, one multiplier bit per cycle.
- CALC divide: restoring division, one quotient bit per cycle; the partial remainder is XLEN+1 bits.
- CALC ends when the counter reaches 0 after the XLEN-th step, then the FSM moves to DONE.
- DONE: applies the sign fixup (two's-complement negate when the recorded sign is set).
  - Remainder sign follows the dividend.
  - Selects the low half (MUL), high half (MULH*), quotient or remainder.
  - Registers the selected value to outResult with outValid=1, then moves to IDLE unconditionally.
- outStall = (state==IDLE && inValid && !flush) || state==CALC. It is 0 in DONE, so the pipeline advances as outValid pulses.
- inValid is ignored in DONE, so the consumed instruction never restarts.
- flush in any state forces IDLE on the next edge. outValid stays 0 and no result is produced; flush overrides a same-cycle start.
- outResult and outWrReg hold their last value outside outValid pulses.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, outValid=0, outStall=0, busy=0, outResult=0, outWrReg=0, counter=0.
- Reset release takes effect on the next clk edge.
- Reset mid-CALC aborts the op with no result.
- Normal op, accepted in cycle 0 (IDLE):
  - CALC occupies cycles 1..XLEN.
  - DONE is cycle XLEN+1, with outValid high on that cycle's registered outputs.
  - outStall is high in cycles 0..XLEN (XLEN+1 cycles).
  - Total latency is XLEN+1 cycles from acceptance to outValid.
- Special case, accepted in cycle 0: outStall high in cycle 0 only; outValid in cycle 1.
- Back-to-back M ops: the second op is accepted in the IDLE cycle after DONE, one bubble cycle.
- outStall is combinational from inValid in IDLE. All other outputs are registered.

## Test plan
- Basic multiply: MUL 7 * -3 (rs2 = 0xFFFF_FFFF_FFFF_FFFD).
  - outValid at cycle 65, outResult = 0xFFFF_FFFF_FFFF_FFEB, outWrReg as issued.
  - outStall high for exactly 65 cycles.
- High-half multiply:
  - MULHU all-ones * all-ones -> 0xFFFF_FFFF_FFFF_FFFE.
  - MULH -1 * -1 -> 0.
  - MULHSU -1 * 2 -> 0xFFFF_FFFF_FFFF_FFFF.
- Divide/remainder: DIV -7/2 -> -3; REM -7/2 -> -1; DIVU 100/7 -> 14; REMU 100/7 -> 2. All at cycle 65.
- Special cases:
  - DIV 5/0 -> all-ones and REM 5/0 -> 5, each with outValid at cycle 1.
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
  - REM of the same operands -> 0.
- Flush: flush at cycle 20 of a DIV -> IDLE at cycle 21, outStall=0, no outValid pulse.
  - A following MUL 3*4 returns 12 normally.
- Reset: rst_n asserted mid-CALC -> all outputs 0 immediately, without waiting for a clk edge.
  - Back-to-back MUL 2*3 then MUL 4*5 -> outValid at cycles 65 and 131, results 6 and 20.
